// File: rtl/ycc_pkg.sv
// Shared constants for the RGB -> YCbCr 4:2:2 front end: BT.601 coefficients,
// state_Ycc byte tags, saturation bounds, serializer states and the pair record.
package ycc_pkg;
  localparam int RND     = 128;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  localparam logic signed [8:0] KY_R  =  9'sd77;
  localparam logic signed [8:0] KY_G  =  9'sd150;
  localparam logic signed [8:0] KY_B  =  9'sd29;
  localparam logic signed [8:0] KCB_R = -9'sd43;
  localparam logic signed [8:0] KCB_G = -9'sd85;
  localparam logic signed [8:0] KCB_B =  9'sd128;
  localparam logic signed [8:0] KCR_R =  9'sd128;
  localparam logic signed [8:0] KCR_G = -9'sd107;
  localparam logic signed [8:0] KCR_B = -9'sd21;

  localparam logic [1:0] ST_Y0 = 2'd0;
  localparam logic [1:0] ST_Y1 = 2'd1;
  localparam logic [1:0] ST_CB = 2'd2;
  localparam logic [1:0] ST_CR = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_EMIT0, S_EMIT1, S_EMIT2, S_EMIT3} ser_state_e;

  typedef struct packed {
    logic signed [7:0] y0;
    logic signed [7:0] y1;
    logic signed [7:0] cb;
    logic signed [7:0] cr;
  } ycc_pair_t;

  function automatic logic signed [7:0] sat8(input logic signed [19:0] v);
    if (v > SAT_MAX)      return 8'(SAT_MAX);
    else if (v < SAT_MIN) return 8'(SAT_MIN);
    else                  return v[7:0];
  endfunction
endpackage

// File: rtl/ycc_mac.sv
// One colour channel: products -> sum -> round/shift/saturate, three register stages.
// With CHROMA_AVG_EN the stage-2 sum is also delivered, aligned with the result.
module ycc_mac
  import ycc_pkg::*;
#(
  parameter logic signed [8:0] K_R  = '0,
  parameter logic signed [8:0] K_G  = '0,
  parameter logic signed [8:0] K_B  = '0,
  parameter bit                LUMA = 1'b0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         i_r,
  input  logic [7:0]         i_g,
  input  logic [7:0]         i_b,
`ifdef CHROMA_AVG_EN
  output logic signed [17:0] o_sum,
`endif
  output logic signed [7:0]  o_val
);
  logic signed [17:0] r_pr, r_pg, r_pb, r_sum;
  logic signed [17:0] w_rnd;
  logic signed [19:0] w_sh;
  logic signed [7:0]  r_val;

  always_comb begin
    w_rnd = r_sum + 18'(RND);
    w_sh  = 20'(w_rnd >>> 8);
    // luma is level-shifted to signed after the divide
    if (LUMA) w_sh = w_sh - 20'sd128;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_pr  <= '0;
      r_pg  <= '0;
      r_pb  <= '0;
      r_sum <= '0;
      r_val <= '0;
    end else begin
      r_pr  <= $signed({1'b0, i_r}) * K_R;
      r_pg  <= $signed({1'b0, i_g}) * K_G;
      r_pb  <= $signed({1'b0, i_b}) * K_B;
      r_sum <= r_pr + r_pg + r_pb;
      r_val <= sat8(w_sh);
    end

`ifdef CHROMA_AVG_EN
  logic signed [17:0] r_sum_d;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_sum_d <= '0;
    else            r_sum_d <= r_sum;
  assign o_sum = r_sum_d;
`endif

  assign o_val = r_val;
endmodule

// File: rtl/rgb_to_ycc422.sv
// RGB888 -> signed YCbCr 4:2:2 byte stream (Y0,Y1,Cb,Cr) for the ping-pong buffer.
// CHROMA_AVG_EN: average pair chroma from stage-2 sums instead of using the even pixel.
module rgb_to_ycc422
  import ycc_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [7:0]        pix_r,
  input  logic [7:0]        pix_g,
  input  logic [7:0]        pix_b,
  output logic signed [7:0] img_out,
  output logic [1:0]        state_Ycc,
  output logic              data_en,
  output logic              pair_err
);
  localparam int STAGES = 3;

  logic                w_acc, w_odd_in, w_done, w_take;
  logic                r_phase, r_perr, r_pend_vld, r_den;
  logic [STAGES:1]     r_vld_pipe, r_odd_pipe;
  logic signed [7:0]   w_y, r_ev_y, r_img;
  logic signed [7:0]   r_e_y1, r_e_cb, r_e_cr;
  logic [1:0]          r_st;
  ycc_pair_t           w_new, w_src, r_pend;
  ser_state_e          r_state, w_nxt;
`ifdef CHROMA_AVG_EN
  logic signed [7:0]   w_cb_unused, w_cr_unused;
  logic signed [17:0]  w_ys_unused, w_cbs, w_crs, r_ev_cbs, r_ev_crs;
`else
  logic signed [7:0]   w_cb, w_cr, r_ev_cb, r_ev_cr;
`endif

  ycc_mac #(.K_R(KY_R), .K_G(KY_G), .K_B(KY_B), .LUMA(1'b1)) u_mac_y (
    .sys_clk, .sys_rst_n, .i_r(pix_r), .i_g(pix_g), .i_b(pix_b),
`ifdef CHROMA_AVG_EN
    .o_sum(w_ys_unused),
`endif
    .o_val(w_y)
  );
  ycc_mac #(.K_R(KCB_R), .K_G(KCB_G), .K_B(KCB_B), .LUMA(1'b0)) u_mac_cb (
    .sys_clk, .sys_rst_n, .i_r(pix_r), .i_g(pix_g), .i_b(pix_b),
`ifdef CHROMA_AVG_EN
    .o_sum(w_cbs), .o_val(w_cb_unused)
`else
    .o_val(w_cb)
`endif
  );
  ycc_mac #(.K_R(KCR_R), .K_G(KCR_G), .K_B(KCR_B), .LUMA(1'b0)) u_mac_cr (
    .sys_clk, .sys_rst_n, .i_r(pix_r), .i_g(pix_g), .i_b(pix_b),
`ifdef CHROMA_AVG_EN
    .o_sum(w_crs), .o_val(w_cr_unused)
`else
    .o_val(w_cr)
`endif
  );

  // An odd pixel is only admitted when nothing else can claim the pending slot,
  // so a completing pair always finds either the serializer or r_pend free.
  assign w_odd_in  = r_phase & ~pix_sof;
  assign pix_ready = ~(r_phase & (r_pend_vld | (|(r_vld_pipe & r_odd_pipe))));
  assign w_acc     = pix_valid & pix_ready;
  assign w_done    = r_vld_pipe[STAGES] & r_odd_pipe[STAGES];

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_phase    <= 1'b0;
      r_vld_pipe <= '0;
      r_odd_pipe <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
      r_odd_pipe <= {r_odd_pipe[STAGES-1:1], w_acc & w_odd_in};
      if (w_acc) r_phase <= ~w_odd_in;
      r_perr     <= w_acc & pix_sof & r_phase;
    end

  // even half of the pair; a sof pixel simply overwrites an orphaned one
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_ev_y <= '0;
`ifdef CHROMA_AVG_EN
      r_ev_cbs <= '0;
      r_ev_crs <= '0;
`else
      r_ev_cb  <= '0;
      r_ev_cr  <= '0;
`endif
    end else if (r_vld_pipe[STAGES] && !r_odd_pipe[STAGES]) begin
      r_ev_y <= w_y;
`ifdef CHROMA_AVG_EN
      r_ev_cbs <= w_cbs;
      r_ev_crs <= w_crs;
`else
      r_ev_cb  <= w_cb;
      r_ev_cr  <= w_cr;
`endif
    end

  always_comb begin
    w_new.y0 = r_ev_y;
    w_new.y1 = w_y;
`ifdef CHROMA_AVG_EN
    w_new.cb = sat8((20'(r_ev_cbs) + 20'(w_cbs) + 20'sd256) >>> 9);
    w_new.cr = sat8((20'(r_ev_crs) + 20'(w_crs) + 20'sd256) >>> 9);
`else
    w_new.cb = r_ev_cb;
    w_new.cr = r_ev_cr;
`endif
  end

  assign w_take = ((r_state == S_IDLE) || (r_state == S_EMIT3)) && (r_pend_vld || w_done);
  assign w_src  = r_pend_vld ? r_pend : w_new;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_e_y1     <= '0;
      r_e_cb     <= '0;
      r_e_cr     <= '0;
    end else begin
      if (w_done && (r_pend_vld || !w_take)) r_pend <= w_new;
      r_pend_vld <= (r_pend_vld && !w_take) || (w_done && (r_pend_vld || !w_take));
      if (w_take) begin
        r_e_y1 <= w_src.y1;
        r_e_cb <= w_src.cb;
        r_e_cr <= w_src.cr;
      end
    end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_nxt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_nxt = S_EMIT0;
      S_EMIT0: w_nxt = S_EMIT1;
      S_EMIT1: w_nxt = S_EMIT2;
      S_EMIT2: w_nxt = S_EMIT3;
      S_EMIT3: w_nxt = w_take ? S_EMIT0 : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // byte outputs registered alongside the state they belong to
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_img <= '0;
      r_st  <= ST_Y0;
      r_den <= 1'b0;
    end else begin
      r_den <= (w_nxt != S_IDLE);
      case (w_nxt)
        S_EMIT0: begin r_img <= w_src.y0; r_st <= ST_Y0; end
        S_EMIT1: begin r_img <= r_e_y1;   r_st <= ST_Y1; end
        S_EMIT2: begin r_img <= r_e_cb;   r_st <= ST_CB; end
        S_EMIT3: begin r_img <= r_e_cr;   r_st <= ST_CR; end
        default: r_st <= ST_Y0;
      endcase
    end

  assign img_out   = r_img;
  assign state_Ycc = r_st;
  assign data_en   = r_den;
  assign pair_err  = r_perr;
endmodule

// File: tb/tb_rgb_to_ycc422.sv
// Directed bench for rgb_to_ycc422: known colour pairs, streaming, sof resync, reset.
// Expected bytes are hand-derived from the BT.601 fixed-point formulas.
module tb_rgb_to_ycc422;
  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              pix_valid, pix_sof, pix_ready;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic signed [7:0] img_out;
  logic [1:0]        state_Ycc;
  logic              data_en, pair_err;

  int vectors = 0;
  int miscompares = 0;

  rgb_to_ycc422 dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .img_out(img_out), .state_Ycc(state_Ycc), .data_en(data_en), .pair_err(pair_err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic sof);
    int n;
    @(negedge sys_clk);
    pix_valid = 1'b1; pix_r = r; pix_g = g; pix_b = b; pix_sof = sof;
    n = 0;
    while (!pix_ready && n < 50) begin @(negedge sys_clk); n++; end
    if (n >= 50) chk("ready timeout", pix_ready, 1);
    @(posedge sys_clk); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic expect_pair(input string tag, input int y0, input int y1, input int cb, input int cr);
    int n;
    int e [4];
    e[0] = y0; e[1] = y1; e[2] = cb; e[3] = cr;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!data_en && n < 40);
    chk({tag, " latency"}, n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge sys_clk);
      chk({tag, " data_en"}, data_en, 1);
      chk({tag, " state_Ycc"}, state_Ycc, k);
      chk({tag, " img_out"}, img_out, e[k]);
    end
    @(negedge sys_clk);
    chk({tag, " idle data_en"}, data_en, 0);
    chk({tag, " idle state_Ycc"}, state_Ycc, 0);
    chk({tag, " idle hold"}, img_out, cr);
  endtask

  initial begin
    int idx, acc_cnt, vcyc, den_cnt, n, ecnt;
    bit acc, started, ended;
    int exp_b;
    sys_rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst pix_ready", pix_ready, 1);
    chk("rst img_out", img_out, 0);
    chk("rst state_Ycc", state_Ycc, 0);
    chk("rst data_en", data_en, 0);
    chk("rst pair_err", pair_err, 0);
    sys_rst_n = 1'b1;

    send(8'd255, 8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b0);
    expect_pair("white", 127, 127, 0, 0);

    send(8'd0, 8'd0, 8'd0, 1'b0);
    send(8'd0, 8'd0, 8'd0, 1'b0);
    expect_pair("black", -128, -128, 0, 0);

    send(8'd255, 8'd0, 8'd0, 1'b0);
    send(8'd0, 8'd0, 8'd255, 1'b0);
`ifdef CHROMA_AVG_EN
    expect_pair("red/blue avg", -51, -99, 42, 53);
`else
    expect_pair("red/blue", -51, -99, -43, 127);
`endif

    // orphan even pixel, then sof restarts the pair
    send(8'd255, 8'd0, 8'd0, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b1);
    @(negedge sys_clk);
    chk("sof pair_err pulse", pair_err, 1);
    chk("sof no data_en", data_en, 0);
    @(negedge sys_clk);
    chk("sof pair_err single", pair_err, 0);
    chk("sof no data_en 2", data_en, 0);
    send(8'd0, 8'd0, 8'd0, 1'b0);
    expect_pair("sof pair", 127, -128, 0, 0);

    // 64 grey pixels back to back: Y = 4*i - 128, chroma 0
    idx = 0; acc_cnt = 0; vcyc = 0; den_cnt = 0; started = 0; ended = 0;
    @(negedge sys_clk);
    pix_valid = 1'b1; pix_r = 8'd0; pix_g = 8'd0; pix_b = 8'd0;
    for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
      if (cyc > 0) @(negedge sys_clk);
      if (data_en) begin
        case (den_cnt % 4)
          0: exp_b = 8 * (den_cnt / 4) - 128;
          1: exp_b = 8 * (den_cnt / 4) + 4 - 128;
          default: exp_b = 0;
        endcase
        chk("stream state_Ycc", state_Ycc, den_cnt % 4);
        chk("stream img_out", img_out, exp_b);
        den_cnt++;
        started = 1;
      end else if (started) ended = 1;
      if (pix_valid) vcyc++;
      acc = pix_valid && pix_ready;
      @(posedge sys_clk); #1;
      if (acc) begin
        idx++; acc_cnt++;
        if (idx == 64) pix_valid = 1'b0;
        else begin
          pix_r = 8'(idx * 4); pix_g = 8'(idx * 4); pix_b = 8'(idx * 4);
        end
      end
    end
    chk("stream ended", ended, 1);
    chk("stream contiguous bytes", den_cnt, 128);
    chk("stream accepted", acc_cnt, 64);
    chk("stream ready duty", (vcyc >= 124 && vcyc <= 130), 1);

    // reset during EMIT2 with an even pixel already in flight
    send(8'd255, 8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd0, 8'd0, 1'b0);
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!(data_en && state_Ycc == 2'd2) && n < 40);
    chk("reach EMIT2", state_Ycc, 2);
    sys_rst_n = 1'b0;
    #1;
    chk("mid rst img_out", img_out, 0);
    chk("mid rst data_en", data_en, 0);
    chk("mid rst state_Ycc", state_Ycc, 0);
    chk("mid rst pix_ready", pix_ready, 1);
    chk("mid rst pair_err", pair_err, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ecnt = 0;
    repeat (12) begin
      @(negedge sys_clk);
      if (data_en || pair_err) ecnt++;
    end
    chk("post rst quiet", ecnt, 0);
    send(8'd0, 8'd0, 8'd0, 1'b0);
    send(8'd0, 8'd0, 8'd0, 1'b0);
    expect_pair("post rst black", -128, -128, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
